// File: rtl/ube_cycle_sequencer_pkg.sv
// Shared definitions for the UBE cycle sequencer: state codes, transfer
// function codes, default NXM timeout and the last-cycle test.
package ube_seq_pkg;

  typedef logic [1:0] ubeState_t;
  typedef logic [1:0] ubeFunc_t;

  localparam ubeState_t stIDLE = 2'd0;
  localparam ubeState_t stREQ  = 2'd1;
  localparam ubeState_t stINC  = 2'd2;
  localparam ubeState_t stDONE = 2'd3;

  localparam ubeFunc_t ubeDATI  = 2'd0;
  localparam ubeFunc_t ubeDATO  = 2'd1;
  localparam ubeFunc_t ubeDATOB = 2'd2;

  localparam int ubeTIMEOUT = 255;

  // The count steps by two, so both 0xFFFE and 0xFFFF are the final word.
  function automatic logic isLastCycle(input logic [15:0] cc);
    return (cc[15:1] == 15'h7FFF);
  endfunction

endpackage

// File: rtl/ube_cycle_sequencer_if.sv
// Bundle of CSR strobes, cycle-count value and adapter DMA handshake that
// connects the sequencer to the register file and the Unibus adapter.
interface ube_cycle_sequencer_if;
  import ube_seq_pkg::*;

  logic        devRESET;
  logic        goWRITE;
  logic        stopWRITE;
  logic        intENA;
  ubeFunc_t    ubeFUNC;
  logic [15:0] regCC;
  logic        dmaACK;
  logic        dmaNXM;
  logic        intACK;
  logic        dmaREQ;
  logic        dmaWRITE;
  logic        dmaBYTE;
  logic        ubeINC;
  logic        ubeBUSY;
  logic        ubeDONE;
  logic        ubeNXM;
  logic        intREQ;

  modport master (
    input  devRESET, goWRITE, stopWRITE, intENA, ubeFUNC, regCC,
           dmaACK, dmaNXM, intACK,
    output dmaREQ, dmaWRITE, dmaBYTE, ubeINC, ubeBUSY, ubeDONE, ubeNXM, intREQ
  );

  modport slave (
    output devRESET, goWRITE, stopWRITE, intENA, ubeFUNC, regCC,
           dmaACK, dmaNXM, intACK,
    input  dmaREQ, dmaWRITE, dmaBYTE, ubeINC, ubeBUSY, ubeDONE, ubeNXM, intREQ
  );

endinterface

// File: rtl/ube_cycle_sequencer_timeout.sv
// Loadable up-counter with clear/enable; o_tc flags the count at TIMEOUT-1,
// used to detect a DMA request the adapter never answers.
module ube_timeout
  import ube_seq_pkg::*;
#(
  parameter int TIMEOUT = ubeTIMEOUT,
  parameter int TOWIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_load,
  input  logic [TOWIDTH-1:0] i_loadVal,
  output logic               o_tc
);

  logic [TOWIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_count <= '0;
    else if (i_clr)
      r_count <= '0;
    else if (i_load)
      r_count <= i_loadVal;
    else if (i_en)
      r_count <= r_count + TOWIDTH'(1);
  end

  assign o_tc = (r_count == TOWIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/ube_cycle_sequencer.sv
// UBE DMA cycle sequencer: issues DMA requests, strobes the cycle-count
// increment per completed word, and reports completion, NXM and interrupts.
module ube_cycle_sequencer
  import ube_seq_pkg::*;
#(
  parameter int TIMEOUT = ubeTIMEOUT,
  parameter int TOWIDTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  ube_cycle_sequencer_if.master bus
);

  ubeState_t r_state;
  ubeState_t w_next;
  ubeFunc_t  r_func;
  logic      r_done;
  logic      r_nxm;
  logic      r_intReq;
  logic      w_tc;
  logic      w_go;
  logic      w_toNxm;
  logic      w_finish;
  logic      w_intClr;
  logic      w_intSet;

  // Stop takes precedence over a bus error, and a bus error over a plain ACK.
  always_comb begin
    w_next  = r_state;
    w_toNxm = 1'b0;
    case (r_state)
      stIDLE: if (bus.goWRITE) w_next = stREQ;
      stREQ: begin
        if (bus.stopWRITE)
          w_next = stDONE;
        else if (bus.dmaNXM || w_tc) begin
          w_next  = stDONE;
          w_toNxm = 1'b1;
        end else if (bus.dmaACK)
          w_next = stINC;
      end
      stINC: begin
        if (bus.stopWRITE || isLastCycle(bus.regCC))
          w_next = stDONE;
        else
          w_next = stREQ;
      end
      default: w_next = stIDLE;
    endcase
  end

  assign w_go     = (r_state == stIDLE) && bus.goWRITE;
  assign w_finish = ((r_state == stREQ) || (r_state == stINC)) && (w_next == stDONE);
  assign w_intClr = bus.intACK || bus.goWRITE;
  assign w_intSet = (r_state == stDONE) && bus.intENA;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= stIDLE;
      r_func   <= ubeDATI;
      r_done   <= 1'b1;
      r_nxm    <= 1'b0;
      r_intReq <= 1'b0;
    end else if (bus.devRESET) begin
      r_state  <= stIDLE;
      r_func   <= ubeDATI;
      r_done   <= 1'b1;
      r_nxm    <= 1'b0;
      r_intReq <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_func <= bus.ubeFUNC;
        r_done <= 1'b0;
        r_nxm  <= 1'b0;
      end else if (w_finish) begin
        r_done <= 1'b1;
        if (w_toNxm) r_nxm <= 1'b1;
      end
      if (w_intClr)
        r_intReq <= 1'b0;
      else if (w_intSet)
        r_intReq <= 1'b1;
    end
  end

  ube_timeout #(
    .TIMEOUT (TIMEOUT),
    .TOWIDTH (TOWIDTH)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state != stREQ),
    .i_en      (r_state == stREQ),
    .i_load    (1'b0),
    .i_loadVal ({TOWIDTH{1'b0}}),
    .o_tc      (w_tc)
  );

  // Reserved function code 3 decodes as a read.
  assign bus.dmaREQ   = (r_state == stREQ);
  assign bus.dmaWRITE = (r_state == stREQ) && ((r_func == ubeDATO) || (r_func == ubeDATOB));
  assign bus.dmaBYTE  = (r_state == stREQ) && (r_func == ubeDATOB);
  assign bus.ubeINC   = (r_state == stINC);
  assign bus.ubeBUSY  = (r_state == stREQ) || (r_state == stINC);
  assign bus.ubeDONE  = r_done;
  assign bus.ubeNXM   = r_nxm;
  assign bus.intREQ   = r_intReq;

endmodule

// File: tb/tb_ube_cycle_sequencer.sv
// Self-checking bench for ube_cycle_sequencer: a cycle-level behavioural
// model compared every cycle, plus directed literal checks per scenario.
module tb_ube_cycle_sequencer;

  localparam int TO = 16;

  logic clk;
  logic rst;
  int   nCompared;
  int   nMismatched;
  bit   checkEn;

  int reqCycles;
  int incCount;
  bit finished;

  ube_cycle_sequencer_if bus();

  ube_cycle_sequencer #(
    .TIMEOUT (TO),
    .TOWIDTH (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: expected outputs as plain flags plus a REQ-cycle count.
  bit       eReq, eInc, eDone, eNxm, eInt, eDonePhase;
  bit       wasReq, wasInc, wasDone, intSet, intClr;
  int       waitCnt;
  bit [1:0] mFunc;

  function automatic void modelReset();
    eReq = 0; eInc = 0; eDone = 1; eNxm = 0; eInt = 0; eDonePhase = 0;
    waitCnt = 0; mFunc = 2'd0;
  endfunction

  function automatic void endTransfer(input bit nxm);
    eReq = 0; eInc = 0; eDone = 1; eDonePhase = 1;
    if (nxm) eNxm = 1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst || bus.devRESET)
      modelReset();
    else begin
      wasReq  = eReq;
      wasInc  = eInc;
      wasDone = eDonePhase;
      intSet  = wasDone && bus.intENA;
      intClr  = bus.intACK || bus.goWRITE;
      eDonePhase = 0;
      if (wasReq) begin
        waitCnt = waitCnt + 1;
        if (bus.stopWRITE) endTransfer(0);
        else if (bus.dmaNXM || waitCnt == TO) endTransfer(1);
        else if (bus.dmaACK) begin eReq = 0; eInc = 1; end
      end else if (wasInc) begin
        eInc = 0;
        if (bus.stopWRITE || bus.regCC >= 16'hFFFE) endTransfer(0);
        else begin eReq = 1; waitCnt = 0; end
      end else if (!wasDone && bus.goWRITE) begin
        eReq = 1; waitCnt = 0; mFunc = bus.ubeFUNC; eDone = 0; eNxm = 0;
      end
      if (intClr) eInt = 0;
      else if (intSet) eInt = 1;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  logic [7:0] actVec, expVec;
  always @(negedge clk) begin
    if (checkEn) begin
      actVec = {bus.dmaREQ, bus.dmaWRITE, bus.dmaBYTE, bus.ubeINC,
                bus.ubeBUSY, bus.ubeDONE, bus.ubeNXM, bus.intREQ};
      expVec = {eReq, eReq && (mFunc == 2'd1 || mFunc == 2'd2), eReq && (mFunc == 2'd2),
                eInc, eReq || eInc, eDone, eNxm, eInt};
      nCompared++;
      if (actVec !== expVec) begin
        nMismatched++;
        $display("[TB] FAIL cycleOutputs @%0t: got %b expected %b (REQ WR BY INC BSY DN NXM INT)",
                 $time, actVec, expVec);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Pulses GO for one cycle; returns at the negedge where REQ should be visible.
  task automatic applyStimulus(input logic [1:0] func, input logic [15:0] cc);
    @(negedge clk);
    bus.regCC   = cc;
    bus.ubeFUNC = func;
    bus.goWRITE = 1'b1;
    @(negedge clk);
    bus.goWRITE = 1'b0;
  endtask

  // Adapter plus CC register stand-in; runs until DONE or the cycle budget expires.
  task automatic runTransfer(input int ackDelay, input bit nxmWithAck, input bit neverAck, input int budget);
    int waitC;
    bit prevInc;
    waitC = 0; prevInc = 0; reqCycles = 0; incCount = 0; finished = 0;
    for (int c = 0; c < budget && !finished; c++) begin
      if (c > 0) @(negedge clk);
      if (prevInc) bus.regCC = bus.regCC + 16'd2;
      prevInc = bus.ubeINC;
      if (bus.ubeINC) incCount++;
      if (bus.ubeDONE && !bus.ubeBUSY)
        finished = 1;
      else if (bus.dmaREQ) begin
        reqCycles++;
        waitC++;
        if (!neverAck && waitC > ackDelay) begin
          bus.dmaACK = 1'b1; bus.dmaNXM = nxmWithAck;
        end else begin
          bus.dmaACK = 1'b0; bus.dmaNXM = 1'b0;
        end
      end else begin
        bus.dmaACK = 1'b0; bus.dmaNXM = 1'b0; waitC = 0;
      end
    end
    bus.dmaACK = 1'b0;
    bus.dmaNXM = 1'b0;
    nCompared++;
    if (!finished) begin
      nMismatched++;
      $display("[TB] FAIL transferDone: got busy after %0d cycles expected DONE", budget);
    end
  endtask

  initial begin
    nCompared = 0; nMismatched = 0; checkEn = 0;
    rst = 1'b0;
    bus.devRESET = 0; bus.goWRITE = 0; bus.stopWRITE = 0; bus.intENA = 0;
    bus.ubeFUNC = 2'd0; bus.regCC = 16'h0; bus.dmaACK = 0; bus.dmaNXM = 0; bus.intACK = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    checkEn = 1;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("resetDone", bus.ubeDONE, 1);
    checkOutput("resetReq", bus.dmaREQ, 0);
    checkOutput("resetBusy", bus.ubeBUSY, 0);
    checkOutput("resetInt", bus.intREQ, 0);

    $display("[TB] DATO from 0xFFFA, ACK after 2 cycles");
    applyStimulus(2'd1, 16'hFFFA);
    checkOutput("goLatencyReq", bus.dmaREQ, 1);
    checkOutput("datoWrite", bus.dmaWRITE, 1);
    checkOutput("datoByte", bus.dmaBYTE, 0);
    runTransfer(2, 0, 0, 200);
    checkOutput("t1Incs", incCount, 3);
    checkOutput("t1ReqCycles", reqCycles, 9);
    checkOutput("t1FinalCC", bus.regCC, 16'h0000);
    checkOutput("t1Done", bus.ubeDONE, 1);
    checkOutput("t1Nxm", bus.ubeNXM, 0);
    @(negedge clk);
    checkOutput("t1NoInt", bus.intREQ, 0);

    $display("[TB] DATI from 0x0000, immediate ACK, interrupt enabled");
    bus.intENA = 1;
    applyStimulus(2'd0, 16'h0000);
    runTransfer(0, 0, 0, 70000);
    checkOutput("t2Incs", incCount, 32768);
    checkOutput("t2FinalCC", bus.regCC, 16'h0000);
    @(negedge clk);
    checkOutput("t2IntSet", bus.intREQ, 1);
    bus.intACK = 1;
    @(negedge clk);
    bus.intACK = 0;
    checkOutput("t2IntAck", bus.intREQ, 0);
    bus.intENA = 0;

    $display("[TB] NXM timeout and bus error");
    applyStimulus(2'd0, 16'hFFF0);
    runTransfer(0, 0, 1, 100);
    checkOutput("t3ReqCycles", reqCycles, TO);
    checkOutput("t3Incs", incCount, 0);
    checkOutput("t3Nxm", bus.ubeNXM, 1);
    checkOutput("t3Done", bus.ubeDONE, 1);
    applyStimulus(2'd0, 16'hFFF0);
    checkOutput("t3NxmClearedAtGo", bus.ubeNXM, 0);
    runTransfer(0, 1, 0, 100);
    checkOutput("t3bReqCycles", reqCycles, 1);
    checkOutput("t3bIncs", incCount, 0);
    checkOutput("t3bNxm", bus.ubeNXM, 1);

    $display("[TB] stop during REQ and during INC");
    bus.intENA = 1;
    applyStimulus(2'd1, 16'h1000);
    @(negedge clk);
    bus.stopWRITE = 1;
    @(negedge clk);
    bus.stopWRITE = 0;
    checkOutput("t4StopReq", bus.dmaREQ, 0);
    checkOutput("t4StopDone", bus.ubeDONE, 1);
    checkOutput("t4StopNxm", bus.ubeNXM, 0);
    @(negedge clk);
    checkOutput("t4StopInt", bus.intREQ, 1);
    bus.stopWRITE = 1;
    @(negedge clk);
    bus.stopWRITE = 0;
    bus.devRESET = 1;
    @(negedge clk);
    bus.devRESET = 0;
    checkOutput("t4DevResetInt", bus.intREQ, 0);
    applyStimulus(2'd0, 16'h1000);
    bus.dmaACK = 1;
    @(negedge clk);
    bus.dmaACK = 0;
    checkOutput("t4IncPhase", bus.ubeINC, 1);
    bus.stopWRITE = 1;
    @(negedge clk);
    bus.stopWRITE = 0;
    checkOutput("t4StopIncDone", bus.ubeDONE, 1);
    checkOutput("t4StopIncNoInc", bus.ubeINC, 0);
    @(negedge clk);
    applyStimulus(2'd1, 16'h1000);
    bus.devRESET = 1;
    @(negedge clk);
    bus.devRESET = 0;
    checkOutput("t4DevResetReq", bus.dmaREQ, 0);
    checkOutput("t4DevResetBusy", bus.ubeBUSY, 0);
    checkOutput("t4DevResetDone", bus.ubeDONE, 1);
    checkOutput("t4DevResetInt2", bus.intREQ, 0);
    bus.intENA = 0;

    $display("[TB] DATOB, GO while busy, async reset");
    applyStimulus(2'd2, 16'h2000);
    checkOutput("t5Byte", bus.dmaBYTE, 1);
    checkOutput("t5Write", bus.dmaWRITE, 1);
    bus.ubeFUNC = 2'd0;
    bus.goWRITE = 1;
    @(negedge clk);
    bus.goWRITE = 0;
    checkOutput("t5BusyGoReq", bus.dmaREQ, 1);
    checkOutput("t5BusyGoByte", bus.dmaBYTE, 1);
    #3 rst = 1'b0;
    #1;
    checkOutput("t5AsyncReq", bus.dmaREQ, 0);
    checkOutput("t5AsyncBusy", bus.ubeBUSY, 0);
    checkOutput("t5AsyncDone", bus.ubeDONE, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t5IdleAfterReset", bus.ubeBUSY, 0);

    checkEn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/ube_cycle_sequencer.md
Name: ube_cycle_sequencer

Overview:
Sequences Unibus Exerciser (UBE) DMA cycles and drives the cycle-count increment strobe (ubeINC) into the UBE cycle count register. On GO, it repeatedly requests Unibus DMA cycles from the adapter. It pulses ubeINC once per completed cycle and stops when the count wraps through zero. It also detects non-existent-memory timeouts, handles aborts and device resets, and raises a completion interrupt. It sits between the UBE CSR/CC register file and the Unibus adapter DMA port.

Parameters:
TIMEOUT, 255, cycles to wait for dmaACK before declaring NXM (1..65535)
TOWIDTH, 16, width of the internal timeout counter

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low (0 = reset)
devRESET  input  1  synchronous device reset (Unibus INIT)
goWRITE  input  1  single-cycle strobe: CSR GO bit written to 1
stopWRITE  input  1  single-cycle strobe: CSR abort written
intENA  input  1  CSR interrupt enable
ubeFUNC  input  2  transfer function: 0=DATI, 1=DATO, 2=DATOB, 3=reserved (treated as DATI)
regCC  input  16  current cycle count register value
dmaACK  input  1  adapter completed the current DMA cycle
dmaNXM  input  1  adapter reports bus error on the current cycle
intACK  input  1  interrupt acknowledged by the adapter
dmaREQ  output  1  DMA cycle request to the adapter
dmaWRITE  output  1  current cycle is a write (DATO/DATOB)
dmaBYTE  output  1  current cycle is a byte write (DATOB)
ubeINC  output  1  one-cycle strobe: increment CC by two
ubeBUSY  output  1  transfer in progress
ubeDONE  output  1  transfer completed or terminated; sticky
ubeNXM  output  1  terminated by timeout or dmaNXM; sticky
intREQ  output  1  interrupt request

Behaviour:
- Reset (rst=0, asynchronous) and devRESET (synchronous) both have the same effect:
  - State goes to IDLE.
  - All outputs go to 0, except ubeDONE, which goes to 1 (idle-ready).
- States: IDLE, REQ, INC, DONE.
- IDLE:
  - goWRITE → REQ.
  - Entering REQ clears ubeDONE, ubeNXM and intREQ.
  - ubeFUNC is latched at GO.
  - ubeFUNC changes during a transfer are ignored.
- REQ:
  - dmaREQ=1, ubeBUSY=1.
  - dmaWRITE/dmaBYTE are decoded from the latched function.
  - The timeout counter increments each cycle.
  - On dmaACK with dmaNXM=0 → INC.
  - On dmaNXM, or timeout count reaching TIMEOUT-1 → DONE with ubeNXM=1. No ubeINC is issued.
  - If dmaACK and dmaNXM arrive together, dmaNXM wins.
- INC:
  - ubeINC=1 for exactly one cycle; dmaREQ=0; the timeout counter clears.
  - The last-cycle test uses the pre-increment value: last = (regCC[15:1] == 15'h7FFF), i.e. regCC is 0xFFFE or 0xFFFF.
  - If last → DONE; otherwise → REQ. On re-entry to REQ, regCC already holds the incremented value.
- Cycle-count semantics:
  - regCC = 0 at GO performs 32768 cycles.
  - An odd regCC wraps to 0x0001 and terminates.
- DONE:
  - ubeDONE=1, ubeBUSY=0.
  - intREQ is set if intENA=1.
  - Next cycle → IDLE.
- stopWRITE in REQ or INC:
  - → DONE next cycle; dmaREQ drops immediately.
  - Any pending INC strobe still completes if already in INC.
  - ubeNXM is not set.
- goWRITE while busy is ignored. stopWRITE in IDLE is ignored.
- intREQ:
  - Cleared by intACK, goWRITE, or devRESET.
  - If set and clear occur in the same cycle, clear wins.
- dmaREQ never deasserts before dmaACK except on stop, timeout or reset.
- ubeINC never coincides with dmaREQ.
- Latency from goWRITE to first dmaREQ: 1 cycle.
- Per-word cost: ACK latency + 1 (INC) cycles.

Decomposition:
- Package ube_seq_pkg holds:
  - The state enum (IDLE, REQ, INC, DONE).
  - Function codes (ubeDATI, ubeDATO, ubeDATOB).
  - The default TIMEOUT constant.
  - The last-cycle test as a function.
- Sub-module ube_timeout: a loadable up-counter with clear/enable and a terminal-count output, parameterised by TIMEOUT and TOWIDTH.

Test Plan:
- regCC=0xFFFA, ubeFUNC=DATO, ACK 2 cycles after each REQ (CC model increments on ubeINC) → exactly 3 dmaREQ/ubeINC pairs with dmaWRITE=1, dmaBYTE=0, then ubeDONE=1, ubeNXM=0, final CC 0x0000.
- regCC=0x0000, DATI, ACK immediate → 32768 ubeINC pulses, CC wraps to 0, DONE; intENA=1 gives intREQ=1, which clears on intACK.
- regCC=0xFFF0, dmaACK never asserted, TIMEOUT=16 → dmaREQ held 16 cycles, then ubeNXM=1, ubeDONE=1, zero ubeINC pulses; the same result occurs with dmaNXM+dmaACK asserted together.
- Mid-transfer stopWRITE during REQ → dmaREQ low the next cycle, DONE, no further ubeINC; a repeat test with devRESET gives IDLE and intREQ=0.
- Asynchronous rst pulse (not clock-aligned) during REQ → dmaREQ=0 immediately and ubeBUSY=0; goWRITE while busy produces no state change; DATOB gives dmaBYTE=1.
